// File: rtl/timeout_arbiter_if.sv
// Request/grant bus between the timeout requesters and timeout_arbiter.
// cancel_i exists only when TIMEOUT_ARB_CANCEL_EN is defined.
interface timeout_arbiter_if #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned CNT_W   = 30
);
   logic [NUM_REQ-1:0]       req_i;
   logic [NUM_REQ*CNT_W-1:0] len_i;
   logic [NUM_REQ-1:0]       grant_o;
   logic [NUM_REQ-1:0]       done_o;
   logic                     busy_o;
   logic [CNT_W-1:0]         remain_o;
`ifdef TIMEOUT_ARB_CANCEL_EN
   logic [NUM_REQ-1:0]       cancel_i;

   modport master (
      output req_i, len_i, cancel_i,
      input  grant_o, done_o, busy_o, remain_o
   );
   modport slave (
      input  req_i, len_i, cancel_i,
      output grant_o, done_o, busy_o, remain_o
   );
`else
   modport master (
      output req_i, len_i,
      input  grant_o, done_o, busy_o, remain_o
   );
   modport slave (
      input  req_i, len_i,
      output grant_o, done_o, busy_o, remain_o
   );
`endif
endinterface

// File: rtl/timeout_arbiter.sv
// Round-robin sharing of one timeout down-counter among NUM_REQ requesters.
// Define TIMEOUT_ARB_CANCEL_EN to let the owner abort its run via cancel_i.
module timeout_arbiter #(
   parameter int unsigned NUM_REQ   = 4,
   parameter int unsigned CNT_W     = 30,
   parameter int unsigned MAX_CYCLE = 1_000_000_000
) (
   input  logic               clk_i,
   input  logic               rst_i,
   timeout_arbiter_if.slave   bus
);
   localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_TIMING,
      S_DONE
   } state_t;

   state_t             state;
   logic [PTR_W-1:0]   rr_ptr;
   logic [PTR_W-1:0]   owner;

   logic               pick_vld_c;
   logic [PTR_W-1:0]   pick_c;
   logic [CNT_W-1:0]   raw_len_c;
   logic [CNT_W-1:0]   pick_len_c;
   logic [PTR_W-1:0]   next_ptr_c;
   logic [CNT_W-1:0]   len_arr [NUM_REQ];

   for (genvar k = 0; k < NUM_REQ; k++) begin : g_len
      assign len_arr[k] = bus.len_i[k*CNT_W +: CNT_W];
   end

   // First pending requester at or after rr_ptr, plus its clamped length
   always_comb begin
      int unsigned idx;
      idx        = 0;
      pick_vld_c = 1'b0;
      pick_c     = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         idx = i + 32'(rr_ptr);
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!pick_vld_c && bus.req_i[PTR_W'(idx)]) begin
            pick_vld_c = 1'b1;
            pick_c     = PTR_W'(idx);
         end
      end
      raw_len_c = len_arr[pick_c];
      if (raw_len_c == '0)
         pick_len_c = CNT_W'(1);
      else if (raw_len_c > CNT_W'(MAX_CYCLE))
         pick_len_c = CNT_W'(MAX_CYCLE);
      else
         pick_len_c = raw_len_c;
      next_ptr_c = (owner == PTR_W'(NUM_REQ - 1)) ? '0 : owner + PTR_W'(1);
   end

   // Controller: grant, count down, pulse done, rearbitrate
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state        <= S_IDLE;
         rr_ptr       <= '0;
         owner        <= '0;
         bus.grant_o  <= '0;
         bus.done_o   <= '0;
         bus.busy_o   <= 1'b0;
         bus.remain_o <= '0;
      end else begin
         bus.done_o <= '0;
         case (state)
            S_IDLE: begin
               if (pick_vld_c) begin
                  state        <= S_TIMING;
                  owner        <= pick_c;
                  bus.grant_o  <= NUM_REQ'(1) << pick_c;
                  bus.busy_o   <= 1'b1;
                  bus.remain_o <= pick_len_c - CNT_W'(1);
               end
            end
            S_TIMING: begin
`ifdef TIMEOUT_ARB_CANCEL_EN
               if (bus.cancel_i[owner]) begin
                  state        <= S_IDLE;
                  bus.grant_o  <= '0;
                  bus.busy_o   <= 1'b0;
                  bus.remain_o <= '0;
                  rr_ptr       <= next_ptr_c;
               end else
`endif
               if (bus.remain_o == '0) begin
                  state       <= S_DONE;
                  bus.grant_o <= '0;
                  bus.done_o  <= bus.grant_o;
                  rr_ptr      <= next_ptr_c;
               end else begin
                  bus.remain_o <= bus.remain_o - CNT_W'(1);
               end
            end
            S_DONE: begin
               state      <= S_IDLE;
               bus.busy_o <= 1'b0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_timeout_arbiter.sv
// Scoreboard bench for timeout_arbiter: stimulus queues expected grant runs,
// a monitor follows each run cycle by cycle and compares the DUT outputs.
module tb_timeout_arbiter;
   localparam int unsigned NUM_REQ = 4;
   localparam int unsigned CNT_W   = 30;
   localparam int unsigned MAXC    = 20;

   typedef struct {
      logic [NUM_REQ-1:0] grant;
      int                 len;
      int                 gap;   // required cycles since previous grant start, -1 = any
      int                 cut;   // grant cycles before a cancel abort, 0 = none
   } exp_t;

   logic clk;
   logic rst;
   exp_t exp_q[$];
   int   phase;
   int   errors;
   int   checks;
   bit   fin;
   bit   fin_ack;

   timeout_arbiter_if #(.NUM_REQ(NUM_REQ), .CNT_W(CNT_W)) bus ();

   timeout_arbiter #(
      .NUM_REQ  (NUM_REQ),
      .CNT_W    (CNT_W),
      .MAX_CYCLE(MAXC)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: follows the expected run and compares every cycle
   initial begin
      exp_t cur;
      int   rem;
      int   gcnt;
      int   cyc;
      int   last_start;
      phase      = 0;
      errors     = 0;
      checks     = 0;
      cyc        = 0;
      last_start = 0;
      rem        = 0;
      gcnt       = 0;
      cur        = '{grant: '0, len: 0, gap: -1, cut: 0};
      fin_ack    = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (rst) begin
            chk("rst_grant", bus.grant_o, 0);
            chk("rst_done", bus.done_o, 0);
            chk("rst_busy", bus.busy_o, 0);
            chk("rst_remain", bus.remain_o, 0);
            phase = 0;
         end else begin
            case (phase)
               0: begin
                  if (bus.grant_o != '0) begin
                     if (exp_q.size() == 0) begin
                        chk("unexpected_grant", bus.grant_o, 0);
                     end else begin
                        cur = exp_q.pop_front();
                        chk("grant_start", bus.grant_o, cur.grant);
                        chk("remain_start", bus.remain_o, cur.len - 1);
                        chk("busy_start", bus.busy_o, 1);
                        if (cur.gap >= 0) chk("grant_gap", cyc - last_start, cur.gap);
                        rem   = cur.len - 1;
                        gcnt  = 1;
                        phase = 1;
                     end
                     last_start = cyc;
                  end else begin
                     chk("idle_done", bus.done_o, 0);
                     chk("idle_busy", bus.busy_o, 0);
                  end
               end
               1: begin
                  if (cur.cut != 0 && gcnt == cur.cut) begin
                     chk("cancel_grant", bus.grant_o, 0);
                     chk("cancel_done", bus.done_o, 0);
                     chk("cancel_busy", bus.busy_o, 0);
                     chk("cancel_remain", bus.remain_o, 0);
                     phase = 0;
                  end else if (rem == 0) begin
                     chk("done_pulse", bus.done_o, cur.grant);
                     chk("done_grant", bus.grant_o, 0);
                     chk("done_busy", bus.busy_o, 1);
                     chk("done_remain", bus.remain_o, 0);
                     phase = 2;
                  end else begin
                     rem--;
                     gcnt++;
                     chk("run_grant", bus.grant_o, cur.grant);
                     chk("run_remain", bus.remain_o, rem);
                     chk("run_done", bus.done_o, 0);
                  end
               end
               default: begin
                  chk("post_done", bus.done_o, 0);
                  chk("post_grant", bus.grant_o, 0);
                  chk("post_busy", bus.busy_o, 0);
                  phase = 0;
               end
            endcase
         end
         if (fin && !fin_ack) begin
            chk("queue_drained", exp_q.size(), 0);
            fin_ack = 1'b1;
         end
      end
   end

   // Requester model: each cycle, drop the requests whose done was seen
   task automatic step(input logic [NUM_REQ-1:0] drop);
      @(negedge clk);
      bus.req_i = bus.req_i & ~(bus.done_o & drop);
   endtask

   task automatic push(input logic [NUM_REQ-1:0] g, input int len, input int gap, input int cut);
      exp_t e;
      e = '{grant: g, len: len, gap: gap, cut: cut};
      exp_q.push_back(e);
   endtask

   task automatic set_lens(input logic [CNT_W-1:0] l3, input logic [CNT_W-1:0] l2,
                           input logic [CNT_W-1:0] l1, input logic [CNT_W-1:0] l0);
      bus.len_i = {l3, l2, l1, l0};
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      bus.req_i = '0;
`ifdef TIMEOUT_ARB_CANCEL_EN
      bus.cancel_i = '0;
`endif
      step('0);
      step('0);
      rst = 1'b0;
      step('0);
   endtask

   task automatic wait_grant(input int max);
      int n;
      n = 0;
      while (phase != 1 && n < max) begin
         step('0);
         n++;
      end
      if (phase != 1) begin
         $display("FAIL wait_grant: no grant within %0d cycles", max);
         $fatal(1, "grant timeout");
      end
   endtask

   task automatic wait_idle(input int max);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || phase != 0 || bus.req_i != '0) && n < max) begin
         step('1);
         n++;
      end
      if (n >= max) begin
         $display("FAIL wait_idle: still busy after %0d cycles", max);
         $fatal(1, "idle timeout");
      end
      step('1);
      step('1);
   endtask

   initial begin
      int n;
      fin       = 1'b0;
      rst       = 1'b1;
      bus.req_i = '0;
      bus.len_i = '0;
`ifdef TIMEOUT_ARB_CANCEL_EN
      bus.cancel_i = '0;
`endif
      step('0);
      step('0);
      do_reset();

      // Single requester, len 5; a mid-run len change must not matter
      set_lens(30'd0, 30'd0, 30'd0, 30'd5);
      bus.req_i = 4'b0001;
      push(4'b0001, 5, -1, 0);
      wait_grant(10);
      set_lens(30'd0, 30'd0, 30'd0, 30'd2);
      wait_idle(40);

      // All four at once, served 0..3, starts 5 cycles apart
      do_reset();
      set_lens(30'd3, 30'd3, 30'd3, 30'd3);
      bus.req_i = 4'b1111;
      push(4'b0001, 3, -1, 0);
      push(4'b0010, 3, 5, 0);
      push(4'b0100, 3, 5, 0);
      push(4'b1000, 3, 5, 0);
      wait_idle(80);

      // Length 0 becomes 1, oversize clamps to MAX_CYCLE
      do_reset();
      set_lens(30'd3, 30'd0, 30'(MAXC + 7), 30'd4);
      bus.req_i = 4'b0110;
      push(4'b0010, MAXC, -1, 0);
      push(4'b0100, 1, MAXC + 2, 0);
      wait_idle(80);

      // Reset mid-run aborts without done and returns rr_ptr to 0
      do_reset();
      set_lens(30'd10, 30'd0, 30'd0, 30'd0);
      bus.req_i = 4'b1000;
      push(4'b1000, 10, -1, 10);
      wait_grant(10);
      step('0);
      step('0);
      step('0);
      rst       = 1'b1;
      bus.req_i = '0;
      step('0);
      rst = 1'b0;
      step('0);
      set_lens(30'd2, 30'd0, 30'd0, 30'd2);
      bus.req_i = 4'b1001;
      push(4'b0001, 2, -1, 0);
      push(4'b1000, 2, 4, 0);
      wait_idle(40);

      // Requester 0 holds through DONE; requester 1 goes next, then 0 again
      do_reset();
      set_lens(30'd2, 30'd2, 30'd2, 30'd2);
      bus.req_i = 4'b0011;
      push(4'b0001, 2, -1, 0);
      push(4'b0010, 2, 4, 0);
      push(4'b0001, 2, 4, 0);
      n = 0;
      while (exp_q.size() > 1 && n < 40) begin
         step(4'b1110);
         n++;
      end
      wait_idle(40);

`ifdef TIMEOUT_ARB_CANCEL_EN
      // Owner cancel in grant cycle 3 returns to IDLE with no done
      do_reset();
      set_lens(30'd4, 30'd8, 30'd0, 30'd0);
      bus.req_i = 4'b0100;
      push(4'b0100, 8, -1, 3);
      wait_grant(10);
      step('0);
      step('0);
      bus.cancel_i = 4'b0100;
      step('0);
      bus.cancel_i = '0;
      bus.req_i    = '0;
      step('0);
      // Cancel from a non-owner has no effect
      bus.cancel_i = 4'b0001;
      bus.req_i    = 4'b1000;
      push(4'b1000, 4, -1, 0);
      wait_idle(40);
      bus.cancel_i = '0;
`endif

      fin = 1'b1;
      n   = 0;
      while (!fin_ack && n < 10) begin
         step('0);
         n++;
      end
      if (!fin_ack) $display("FAIL final_drain: monitor did not respond");
      $display("Result: errors=%0d of %0d checks", errors + (fin_ack ? 0 : 1), checks);
      $finish;
   end
endmodule
